mmio_pwm_responder: RTL

- Memory-mapped peripheral that answers the processor's data-memory port: responder end of the dmem_address / dmem_data_in / dmem_wren / funct3 / dmem_data_out interface.
- Holds four 8-bit PWM duty registers that drive LED, RGB_R, RGB_G and RGB_B.
- Holds free-running microsecond and millisecond counters that software reads.
- Sits beside the data RAM; its dmem_hit output lets the top-level read mux select it.

---
 rtl/mmio_pwm_responder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mmio_pwm_responder.sv
// Memory-mapped responder for the data-memory port: four 8-bit PWM duty registers
// driving led/red/green/blue, plus free-running micros/millis counters.
module mmio_pwm_responder #(
    parameter int unsigned CLK_FREQ_HZ    = 12000000,
    parameter bit          RGB_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_data_in,
    input  logic        dmem_wren,
    input  logic [2:0]  funct3,
    output logic [31:0] dmem_data_out,
    output logic        dmem_hit,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

    // CLK_FREQ_HZ must be an exact multiple of 1 MHz and at least 2 MHz.
    localparam int unsigned   PRESC      = CLK_FREQ_HZ / 1000000;
    localparam int            PW         = $clog2(PRESC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        REG_ZERO   = 2'b00,
        REG_MICROS = 2'b01,
        REG_MILLIS = 2'b10,
        REG_DUTY   = 2'b11
    } reg_sel_e;

    logic [31:0]   duty_q, duty_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [9:0]    ms_sub_q, ms_sub_d;
    logic [31:0]   micros_q, micros_d;
    logic [31:0]   millis_q, millis_d;
    logic [7:0]    pwm_cnt_q, pwm_cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          hit_q, hit_d;
    logic          led_q, led_d;
    logic          red_q, red_d;
    logic          green_q, green_d;
    logic          blue_q, blue_d;

    logic          in_window;
    reg_sel_e      sel;
    logic [31:0]   reg_word;
    logic [31:0]   byte_shift;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic          presc_wrap;
    logic          ms_wrap;

    assign in_window = (dmem_address[31:4] == 28'hFFFFFFF);
    assign sel       = reg_sel_e'(dmem_address[3:2]);

    always_comb begin
        reg_word = '0;
        case (sel)
            REG_DUTY:   reg_word = duty_q;
            REG_MILLIS: reg_word = millis_q;
            REG_MICROS: reg_word = micros_q;
            default:    reg_word = '0;
        endcase
    end

    assign byte_shift = reg_word >> {dmem_address[1:0], 3'b000};
    assign lane_b     = byte_shift[7:0];
    assign lane_h     = dmem_address[1] ? reg_word[31:16] : reg_word[15:0];

    // Load data is formatted from the current (pre-store) register values, so a
    // read coincident with a store returns the old contents.
    always_comb begin
        rdata_d = '0;
        hit_d   = in_window;
        case (funct3)
            F3_B:  rdata_d = {{24{lane_b[7]}}, lane_b};
            F3_BU: rdata_d = {24'h0, lane_b};
            F3_H:  if (!dmem_address[0]) rdata_d = {{16{lane_h[15]}}, lane_h};
            F3_HU: if (!dmem_address[0]) rdata_d = {16'h0, lane_h};
            F3_W:  if (dmem_address[1:0] == 2'b00) rdata_d = reg_word;
            default: rdata_d = '0;
        endcase
        if (!in_window) rdata_d = '0;
    end

    always_comb begin
        duty_d = duty_q;
        if (dmem_wren && in_window && sel == REG_DUTY) begin
            case (funct3)
                F3_B: duty_d[{dmem_address[1:0], 3'b000} +: 8] = dmem_data_in[7:0];
                F3_H: if (!dmem_address[0]) duty_d[{dmem_address[1], 4'b0000} +: 16] = dmem_data_in[15:0];
                F3_W: if (dmem_address[1:0] == 2'b00) duty_d = dmem_data_in;
                default: duty_d = duty_q;
            endcase
        end
    end

    // Microsecond prescaler feeds micros and a 0..999 sub-counter that feeds millis.
    assign presc_wrap = (presc_q == PRESC_LAST);
    assign ms_wrap    = presc_wrap && (ms_sub_q == 10'd999);
    assign presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
    assign micros_d   = micros_q + {31'b0, presc_wrap};
    assign millis_d   = millis_q + {31'b0, ms_wrap};

    always_comb begin
        ms_sub_d = ms_sub_q;
        if (presc_wrap) ms_sub_d = ms_wrap ? 10'd0 : ms_sub_q + 10'd1;
    end

    assign pwm_cnt_d = pwm_cnt_q + 8'd1;
    assign led_d     = (pwm_cnt_q < duty_q[31:24]);
    assign red_d     = (pwm_cnt_q < duty_q[23:16]) ^ RGB_ACTIVE_LOW;
    assign green_d   = (pwm_cnt_q < duty_q[15:8])  ^ RGB_ACTIVE_LOW;
    assign blue_d    = (pwm_cnt_q < duty_q[7:0])   ^ RGB_ACTIVE_LOW;

    // NOTE: state updates use non-blocking assignments so every register samples
    // the pre-edge values; reset is synchronous and also discards a coincident store.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q    <= '0;
            presc_q   <= '0;
            ms_sub_q  <= '0;
            micros_q  <= '0;
            millis_q  <= '0;
            pwm_cnt_q <= '0;
            rdata_q   <= '0;
            hit_q     <= 1'b0;
            led_q     <= 1'b0;
            red_q     <= RGB_ACTIVE_LOW;
            green_q   <= RGB_ACTIVE_LOW;
            blue_q    <= RGB_ACTIVE_LOW;
        end else begin
            duty_q    <= duty_d;
            presc_q   <= presc_d;
            ms_sub_q  <= ms_sub_d;
            micros_q  <= micros_d;
            millis_q  <= millis_d;
            pwm_cnt_q <= pwm_cnt_d;
            rdata_q   <= rdata_d;
            hit_q     <= hit_d;
            led_q     <= led_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
        end
    end

    assign dmem_data_out = rdata_q;
    assign dmem_hit      = hit_q;
    assign led           = led_q;
    assign red           = red_q;
    assign green         = green_q;
    assign blue          = blue_q;

endmodule
